// File: rtl/pipeline_ctrl_pkg.sv
// Shared stage indices, muldiv FSM encoding and per-hazard stage masks
// for the pipeline hazard controller.
package pipeline_ctrl_pkg;

    localparam int NUM_STG = 5;
    localparam int STG_F   = 0;
    localparam int STG_D   = 1;
    localparam int STG_E   = 2;
    localparam int STG_M   = 3;
    localparam int STG_W   = 4;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} muldiv_state_t;

    function automatic logic [NUM_STG-1:0] stg_bit(input int s);
        logic [NUM_STG-1:0] m;
        m    = '0;
        m[s] = 1'b1;
        return m;
    endfunction

    localparam logic [NUM_STG-1:0] MASK_ALL       = '1;
    // Redirect kills everything younger than memory; memory and writeback retire.
    localparam logic [NUM_STG-1:0] MASK_RD_NULL   = stg_bit(STG_F) | stg_bit(STG_D) | stg_bit(STG_E);
    localparam logic [NUM_STG-1:0] MASK_MW_STALL  = stg_bit(STG_F) | stg_bit(STG_D) | stg_bit(STG_E)
                                                  | stg_bit(STG_M);
    localparam logic [NUM_STG-1:0] MASK_MW_BUBBLE = stg_bit(STG_W);
    localparam logic [NUM_STG-1:0] MASK_HZ_STALL  = stg_bit(STG_F) | stg_bit(STG_D);
    localparam logic [NUM_STG-1:0] MASK_HZ_BUBBLE = stg_bit(STG_E);

endpackage

// File: rtl/muldiv_sequencer.sv
// Busy-counter FSM tracking the execute latency of the iterative multiplier/divider.
module muldiv_sequencer
    import pipeline_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic is_div_i,
    input  logic accept_i,
    output logic busy_o,
    output logic done_o
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    muldiv_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] load;
    logic             launch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        launch  = start_i & accept_i;
        load    = is_div_i ? DIV_LOAD : MULT_LOAD;
        case (state_q)
            IDLE, DONE: begin
                if (launch) begin
                    cnt_d   = load;
                    // Single-cycle ops have nothing to count down.
                    state_d = (load == '0) ? DONE : BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q == BUSY);
    assign done_o = (state_q == DONE);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central stall/bubble/nullify generator: load-use, HI/LO, memory-wait and
// redirect handling, plus sequencing of the multi-cycle mult/div unit.
module pipeline_hazard_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [4:0]         dec_rs,
    input  logic [4:0]         dec_rt,
    input  logic               dec_use_rs,
    input  logic               dec_use_rt,
    input  logic               dec_reads_hilo,
    input  logic               ex_is_load,
    input  logic [4:0]         ex_dest_reg,
    input  logic               ex_muldiv_start,
    input  logic               ex_is_div,
    input  logic               mem_req,
    input  logic               mem_ready,
    input  logic               redirect,
    output logic [NUM_STG-1:0] stall,
    output logic [NUM_STG-1:0] bubble,
    output logic [NUM_STG-1:0] nullify,
    output logic               muldiv_busy,
    output logic               muldiv_done
);

    logic mw, rd, hl, lu, accept;

    assign mw = mem_req & ~mem_ready;
    // A redirect under memory wait is held by the producer until the wait clears.
    assign rd = redirect & ~mw;
    assign hl = dec_reads_hilo & (muldiv_busy | ex_muldiv_start);
    assign lu = ex_is_load & (ex_dest_reg != 5'd0)
              & ((dec_use_rs & (dec_rs == ex_dest_reg)) | (dec_use_rt & (dec_rt == ex_dest_reg)));

    // A start under redirect belongs to a flushed instruction; under MW it will reissue.
    assign accept = ~(mw | rd);

    muldiv_sequencer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_seq (
        .clk      (clk),
        .rst_n    (reset),
        .start_i  (ex_muldiv_start),
        .is_div_i (ex_is_div),
        .accept_i (accept),
        .busy_o   (muldiv_busy),
        .done_o   (muldiv_done)
    );

    always_comb begin
        stall   = '0;
        bubble  = '0;
        nullify = '0;
        if (!reset) begin
            nullify = MASK_ALL;
        end else if (rd) begin
            nullify = MASK_RD_NULL;
        end else if (mw) begin
            stall  = MASK_MW_STALL;
            bubble = MASK_MW_BUBBLE;
        end else if (hl | lu) begin
            stall  = MASK_HZ_STALL;
            bubble = MASK_HZ_BUBBLE;
        end
    end

endmodule
